// File: rtl/jesd204b_rx_link_ctrl.sv
// JESD204B receive link bring-up controller: CGS with RXSLIDE alignment, SYNC~ release, ILAS, DATA.
// Optional macro ERR_MON_EN enables the DATA-state disparity/not-in-table error monitor.
module jesd204b_rx_link_ctrl #(
   parameter int SLIDE_GAP    = 36,
   parameter int CGS_CYCLES   = 4,
   parameter int MAX_SLIDES   = 40,
   parameter int ILAS_MF      = 4,
   parameter int ILAS_TIMEOUT = 4096
) (
   input  logic        i_dclk,
   input  logic        i_rst_n,
   input  logic        i_enable,
   input  logic        i_phy_ready,
   input  logic        i_lmfc,
   input  logic [31:0] i_rx_data,
   input  logic [3:0]  i_rx_charisk,
   input  logic [3:0]  i_rx_err,
   output logic        o_nsync,
   output logic        o_rxslide,
   output logic [2:0]  o_state,
   output logic        o_link_up,
   output logic [5:0]  o_slide_cnt,
   output logic [7:0]  o_fault_cnt
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CGS      = 3'd1,
      SYNC_REL = 3'd2,
      ILAS     = 3'd3,
      DATA     = 3'd4,
      FAULT    = 3'd5
   } state_e;

   localparam int GW = $clog2(SLIDE_GAP + 1);
   localparam int CW = $clog2(CGS_CYCLES + 1);
   localparam int IW = $clog2(ILAS_MF + 1);
   localparam int TW = $clog2(ILAS_TIMEOUT + 1);

   localparam logic [GW-1:0] GAP_MAX   = GW'(SLIDE_GAP);
   localparam logic [CW-1:0] CGS_LAST  = CW'(CGS_CYCLES - 1);
   localparam logic [IW-1:0] ILAS_LAST = IW'(ILAS_MF - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(ILAS_TIMEOUT - 1);
   localparam logic [5:0]    SLIDE_MAX = 6'(MAX_SLIDES);

   logic [1:0]    rstSync_q;
   logic          rstInt_n;

   state_e        state_q, state_d;
   logic [GW-1:0] gapCnt_q, gapCnt_d;
   logic [CW-1:0] cgsCnt_q, cgsCnt_d;
   logic [IW-1:0] ilasCnt_q, ilasCnt_d;
   logic [TW-1:0] tmoCnt_q, tmoCnt_d;
   logic [3:0]    holdCnt_q, holdCnt_d;
   logic [5:0]    slideCnt_q, slideCnt_d;
   logic [7:0]    faultCnt_q, faultCnt_d;
   logic          slide_q, slide_d;
   logic          nsync_q;
   logic          linkUp_q;

   logic [3:0]    isBc, isK280, isK283;
   logic          allBc, anyBc, anyK280, anyK283, linkReq;

`ifdef ERR_MON_EN
   logic [3:0]    errCnt_q, errCnt_d;
`else
   logic          unusedErr;
   assign unusedErr = ^i_rx_err;
`endif

   // Assertion is immediate; release reaches the core only after two clock edges.
   always_ff @(posedge i_dclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rstSync_q <= 2'b00;
      end else begin
         rstSync_q <= {rstSync_q[0], 1'b1};
      end
   end

   assign rstInt_n = rstSync_q[1];

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         isBc[n]   = i_rx_charisk[n] && (i_rx_data[8*n +: 8] == 8'hBC);
         isK280[n] = i_rx_charisk[n] && (i_rx_data[8*n +: 8] == 8'h1C);
         isK283[n] = i_rx_charisk[n] && (i_rx_data[8*n +: 8] == 8'h7C);
      end
   end

   assign allBc   = &isBc;
   assign anyBc   = |isBc;
   assign anyK280 = |isK280;
   assign anyK283 = |isK283;
   assign linkReq = i_enable && i_phy_ready;

   always_comb begin
      state_d    = state_q;
      gapCnt_d   = (gapCnt_q == GAP_MAX) ? gapCnt_q : gapCnt_q + GW'(1);
      slide_d    = 1'b0;
      slideCnt_d = slideCnt_q;
      cgsCnt_d   = cgsCnt_q;
      ilasCnt_d  = ilasCnt_q;
      tmoCnt_d   = tmoCnt_q;
      holdCnt_d  = holdCnt_q;
      faultCnt_d = faultCnt_q;
`ifdef ERR_MON_EN
      errCnt_d   = errCnt_q;
`endif

      if (!linkReq) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: state_d = CGS;
            CGS: begin
               if (allBc) begin
                  cgsCnt_d = cgsCnt_q + CW'(1);
                  if (cgsCnt_q == CGS_LAST) state_d = SYNC_REL;
               end else begin
                  cgsCnt_d = '0;
               end
               // A slide is only due with no comma in sight and the gap counter saturated.
               if (!anyBc && (gapCnt_q == GAP_MAX)) begin
                  if (slideCnt_q == SLIDE_MAX) begin
                     state_d = FAULT;
                  end else begin
                     slide_d    = 1'b1;
                     gapCnt_d   = '0;
                     slideCnt_d = slideCnt_q + 6'd1;
                  end
               end
            end
            SYNC_REL: begin
               tmoCnt_d = tmoCnt_q + TW'(1);
               if (i_lmfc || anyK280) state_d = ILAS;
               if (tmoCnt_q == TMO_LAST) state_d = FAULT;
            end
            ILAS: begin
               tmoCnt_d = tmoCnt_q + TW'(1);
               if (anyK283) begin
                  ilasCnt_d = ilasCnt_q + IW'(1);
                  if (ilasCnt_q == ILAS_LAST) state_d = DATA;
               end
               if (allBc || (tmoCnt_q == TMO_LAST)) state_d = FAULT;
            end
            DATA: begin
`ifdef ERR_MON_EN
               if (i_lmfc) begin
                  errCnt_d = '0;
               end else if (|i_rx_err) begin
                  errCnt_d = errCnt_q + 4'd1;
                  if (errCnt_q == 4'd7) state_d = FAULT;
               end
`endif
            end
            FAULT: begin
               holdCnt_d = holdCnt_q + 4'd1;
               if (holdCnt_q == 4'd15) state_d = CGS;
            end
            default: state_d = IDLE;
         endcase
      end

      // Per-state counters restart whenever their state is freshly entered.
      if (state_d != state_q) begin
         case (state_d)
            CGS: begin
               slideCnt_d = '0;
               cgsCnt_d   = '0;
            end
            SYNC_REL: begin
               tmoCnt_d  = '0;
               ilasCnt_d = '0;
            end
            FAULT: begin
               holdCnt_d = '0;
               if (faultCnt_q != 8'hFF) faultCnt_d = faultCnt_q + 8'd1;
            end
`ifdef ERR_MON_EN
            DATA: errCnt_d = '0;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_dclk or negedge rstInt_n) begin
      if (!rstInt_n) begin
         state_q    <= IDLE;
         gapCnt_q   <= '0;
         cgsCnt_q   <= '0;
         ilasCnt_q  <= '0;
         tmoCnt_q   <= '0;
         holdCnt_q  <= '0;
         slideCnt_q <= '0;
         faultCnt_q <= '0;
         slide_q    <= 1'b0;
         nsync_q    <= 1'b1;
         linkUp_q   <= 1'b0;
`ifdef ERR_MON_EN
         errCnt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         gapCnt_q   <= gapCnt_d;
         cgsCnt_q   <= cgsCnt_d;
         ilasCnt_q  <= ilasCnt_d;
         tmoCnt_q   <= tmoCnt_d;
         holdCnt_q  <= holdCnt_d;
         slideCnt_q <= slideCnt_d;
         faultCnt_q <= faultCnt_d;
         slide_q    <= slide_d;
         nsync_q    <= !((state_d == CGS) || (state_d == FAULT));
         linkUp_q   <= (state_d == DATA);
`ifdef ERR_MON_EN
         errCnt_q   <= errCnt_d;
`endif
      end
   end

   assign o_state     = state_q;
   assign o_nsync     = nsync_q;
   assign o_rxslide   = slide_q;
   assign o_link_up   = linkUp_q;
   assign o_slide_cnt = slideCnt_q;
   assign o_fault_cnt = faultCnt_q;

endmodule

// File: tb/tb_jesd204b_rx_link_ctrl.sv
// Directed self-checking bench for jesd204b_rx_link_ctrl; expected values are hand-derived cycle counts.
// Builds against either setting of ERR_MON_EN.
module tb_jesd204b_rx_link_ctrl;

   localparam logic [31:0] WORD_BC   = 32'hBCBCBCBC;
   localparam logic [31:0] WORD_MIS  = 32'h12345678;
   localparam logic [31:0] WORD_K283 = 32'h7C7C7C7C;
   localparam logic [31:0] WORD_K280 = 32'h0000001C;
   localparam logic [31:0] WORD_IDLE = 32'h00000000;

   logic        i_dclk = 1'b0;
   logic        i_rst_n;
   logic        i_enable;
   logic        i_phy_ready;
   logic        i_lmfc;
   logic [31:0] i_rx_data;
   logic [3:0]  i_rx_charisk;
   logic [3:0]  i_rx_err;
   logic        o_nsync;
   logic        o_rxslide;
   logic [2:0]  o_state;
   logic        o_link_up;
   logic [5:0]  o_slide_cnt;
   logic [7:0]  o_fault_cnt;

   int checkCount = 0;
   int failCount  = 0;

   jesd204b_rx_link_ctrl dut (
      .i_dclk       (i_dclk),
      .i_rst_n      (i_rst_n),
      .i_enable     (i_enable),
      .i_phy_ready  (i_phy_ready),
      .i_lmfc       (i_lmfc),
      .i_rx_data    (i_rx_data),
      .i_rx_charisk (i_rx_charisk),
      .i_rx_err     (i_rx_err),
      .o_nsync      (o_nsync),
      .o_rxslide    (o_rxslide),
      .o_state      (o_state),
      .o_link_up    (o_link_up),
      .o_slide_cnt  (o_slide_cnt),
      .o_fault_cnt  (o_fault_cnt)
   );

   // 100 MHz link clock
   always #5 i_dclk = ~i_dclk;

   // Drive one cycle of inputs, then return 1 ns after the rising edge so outputs are settled
   task automatic applyStimulus(input logic en, input logic rdy, input logic lmfc,
                                input logic [31:0] data, input logic [3:0] k, input logic [3:0] err);
      i_enable     = en;
      i_phy_ready  = rdy;
      i_lmfc       = lmfc;
      i_rx_data    = data;
      i_rx_charisk = k;
      i_rx_err     = err;
      @(posedge i_dclk);
      #1;
   endtask

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // From CGS: complete CGS, release SYNC~ on LMFC, run four ILAS multiframes
   task automatic goData(input string tag);
      repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, WORD_BC, 4'hF, 4'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, WORD_IDLE, 4'h0, 4'h0);
      repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, WORD_K283, 4'hF, 4'h0);
      checkOutput(tag, 32'(o_state), 32'd4);
   endtask

   initial begin
      int slides;
      int lastSlide;
      int minSpace;
      int eventAt;

      // Hold reset from time zero with an idle link
      i_rst_n      = 1'b0;
      i_enable     = 1'b0;
      i_phy_ready  = 1'b0;
      i_lmfc       = 1'b0;
      i_rx_data    = WORD_IDLE;
      i_rx_charisk = 4'h0;
      i_rx_err     = 4'h0;
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, WORD_IDLE, 4'h0, 4'h0);
      checkOutput("reset state", 32'(o_state), 32'd0);
      checkOutput("reset nsync", 32'(o_nsync), 32'd1);
      checkOutput("reset rxslide", 32'(o_rxslide), 32'd0);
      checkOutput("reset link_up", 32'(o_link_up), 32'd0);
      checkOutput("reset slide_cnt", 32'(o_slide_cnt), 32'd0);
      checkOutput("reset fault_cnt", 32'(o_fault_cnt), 32'd0);

      // Release and idle long enough for the slide gap counter to saturate
      i_rst_n = 1'b1;
      repeat (50) applyStimulus(1'b0, 1'b1, 1'b0, WORD_IDLE, 4'h0, 4'h0);
      checkOutput("idle while disabled", 32'(o_state), 32'd0);

      // Clean link bring-up
      $display("[TB] clean link bring-up");
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_BC, 4'hF, 4'h0);
      checkOutput("clean enter CGS", 32'(o_state), 32'd1);
      checkOutput("clean CGS nsync", 32'(o_nsync), 32'd0);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, WORD_BC, 4'hF, 4'h0);
      checkOutput("clean CGS after 3 BC", 32'(o_state), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_BC, 4'hF, 4'h0);
      checkOutput("clean SYNC_REL after 4 BC", 32'(o_state), 32'd2);
      checkOutput("clean SYNC_REL nsync", 32'(o_nsync), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, WORD_IDLE, 4'h0, 4'h0);
      checkOutput("clean ILAS on lmfc", 32'(o_state), 32'd3);
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_K280, 4'h1, 4'h0);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, WORD_K283, 4'hF, 4'h0);
      checkOutput("clean ILAS after 3 K28.3", 32'(o_state), 32'd3);
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_K283, 4'hF, 4'h0);
      checkOutput("clean DATA", 32'(o_state), 32'd4);
      checkOutput("clean link_up", 32'(o_link_up), 32'd1);
      checkOutput("clean slide_cnt", 32'(o_slide_cnt), 32'd0);
      repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
      checkOutput("clean DATA holds", 32'(o_state), 32'd4);

      // PHY drop while in DATA
      applyStimulus(1'b1, 1'b0, 1'b0, WORD_MIS, 4'h0, 4'h0);
      checkOutput("phy drop state", 32'(o_state), 32'd0);
      checkOutput("phy drop link_up", 32'(o_link_up), 32'd0);
      checkOutput("phy drop nsync", 32'(o_nsync), 32'd1);

      // Misaligned for 200 CGS cycles: slides at CGS cycles 0,37,74,111,148,185
      $display("[TB] misaligned alignment search");
      repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, WORD_IDLE, 4'h0, 4'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
      checkOutput("mis enter CGS", 32'(o_state), 32'd1);
      slides    = 0;
      lastSlide = -1;
      minSpace  = 9999;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
         if (o_rxslide) begin
            slides++;
            if ((lastSlide >= 0) && ((i - lastSlide - 1) < minSpace)) minSpace = i - lastSlide - 1;
            lastSlide = i;
         end
      end
      checkOutput("mis slide pulses", slides, 32'd6);
      checkOutput("mis cycles between slides", minSpace, 32'd36);
      checkOutput("mis slide_cnt", 32'(o_slide_cnt), 32'd6);
      goData("mis reaches DATA");
      checkOutput("mis slide_cnt in DATA", 32'(o_slide_cnt), 32'd6);

      // Never aligned: 40 slides, FAULT when the 41st is due at CGS cycle 40*37
      $display("[TB] never aligned");
      repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, WORD_IDLE, 4'h0, 4'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
      slides  = 0;
      eventAt = -1;
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
         if (o_rxslide) slides++;
         if (o_state == 3'd5) begin
            eventAt = i;
            break;
         end
      end
      checkOutput("never FAULT cycle", eventAt, 32'd1480);
      checkOutput("never slides before FAULT", slides, 32'd40);
      checkOutput("never state", 32'(o_state), 32'd5);
      checkOutput("never fault_cnt", 32'(o_fault_cnt), 32'd1);
      checkOutput("never nsync", 32'(o_nsync), 32'd0);
      checkOutput("never slide_cnt", 32'(o_slide_cnt), 32'd40);
      repeat (15) applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
      checkOutput("FAULT held 16 cycles", 32'(o_state), 32'd5);
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
      checkOutput("FAULT retries CGS", 32'(o_state), 32'd1);
      checkOutput("retry slide_cnt cleared", 32'(o_slide_cnt), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
      checkOutput("retry first slide", 32'(o_rxslide), 32'd1);
      checkOutput("retry slide_cnt", 32'(o_slide_cnt), 32'd1);

      // Reset in the middle of a slide pulse
      $display("[TB] reset mid-slide");
      #2;
      i_rst_n = 1'b0;
      #1;
      checkOutput("mid-slide reset rxslide", 32'(o_rxslide), 32'd0);
      checkOutput("mid-slide reset state", 32'(o_state), 32'd0);
      checkOutput("mid-slide reset fault_cnt", 32'(o_fault_cnt), 32'd0);
      checkOutput("mid-slide reset nsync", 32'(o_nsync), 32'd1);
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
      i_rst_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
      checkOutput("release sync edge 1", 32'(o_state), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
      checkOutput("release sync edge 2", 32'(o_state), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
      checkOutput("release then CGS", 32'(o_state), 32'd1);
      slides = 0;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, WORD_MIS, 4'h0, 4'h0);
         if (o_rxslide) slides++;
      end
      checkOutput("no early slide after reset", slides, 32'd0);

      // ILAS never arrives: FAULT exactly ILAS_TIMEOUT cycles after leaving CGS
      $display("[TB] ILAS timeout");
      repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, WORD_BC, 4'hF, 4'h0);
      checkOutput("tmo SYNC_REL", 32'(o_state), 32'd2);
      eventAt = -1;
      for (int n = 1; n <= 5000; n++) begin
         applyStimulus(1'b1, 1'b1, (n == 1), WORD_IDLE, 4'h0, 4'h0);
         if (o_state == 3'd5) begin
            eventAt = n;
            break;
         end
      end
      checkOutput("tmo FAULT cycle", eventAt, 32'd4096);
      checkOutput("tmo fault_cnt", 32'(o_fault_cnt), 32'd1);

      // Back to DATA for the error monitor
      repeat (16) applyStimulus(1'b1, 1'b1, 1'b0, WORD_BC, 4'hF, 4'h0);
      checkOutput("post tmo CGS", 32'(o_state), 32'd1);
      goData("err reaches DATA");
`ifdef ERR_MON_EN
      $display("[TB] error monitor enabled");
      applyStimulus(1'b1, 1'b1, 1'b1, WORD_IDLE, 4'h0, 4'h0);
      repeat (7) applyStimulus(1'b1, 1'b1, 1'b0, WORD_IDLE, 4'h0, 4'h1);
      checkOutput("7 errors stay DATA", 32'(o_state), 32'd4);
      applyStimulus(1'b1, 1'b1, 1'b1, WORD_IDLE, 4'h0, 4'h0);
      repeat (7) applyStimulus(1'b1, 1'b1, 1'b0, WORD_IDLE, 4'h0, 4'h8);
      checkOutput("7 errors after lmfc stay DATA", 32'(o_state), 32'd4);
      applyStimulus(1'b1, 1'b1, 1'b0, WORD_IDLE, 4'h0, 4'h2);
      checkOutput("8th error FAULT", 32'(o_state), 32'd5);
      checkOutput("err fault_cnt", 32'(o_fault_cnt), 32'd2);
`else
      $display("[TB] error monitor disabled");
      repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, WORD_IDLE, 4'h0, 4'hF);
      checkOutput("errors ignored", 32'(o_state), 32'd4);
      checkOutput("errors ignored fault_cnt", 32'(o_fault_cnt), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
